mdu_seq: RTL and testbench
==========================

Name: mdu_seq

Overview:
- Multi-cycle sequencer for the RV64M multiply/divide ops that the decoder flags with ALUCtrl codes 19–30.
- Accepts one operation at a time over a valid/ready handshake and iterates a shared shift-add / restoring-divide datapath one bit per cycle.
- Holds the result until the execute stage consumes it.
- Sits beside the ALU in EXU; while busy (in_ready low) the core stalls IFU/IDU.

Parameters:
- XLEN, 64, datapath width. Only 64 is supported; W ops use the low 32 bits.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  abort current op; the block returns to IDLE next cycle
- in_valid  in  1  operation offered
- in_ready  out  1  block can accept; high only in IDLE
- op  in  5  ALUCtrl code. 19 MUL/MULH, 20 MULHSU, 21 MULHU, 22 MULW, 23 DIV, 24 DIVU, 25 DIVW, 26 DIVUW, 27 REM, 28 REMU, 29 REMW, 30 REMUW
- hl  in  1  hloutalu: select the high product half (for op 19 it distinguishes MULH from MUL)
- src1  in  XLEN  rs1 value
- src2  in  XLEN  rs2 value
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- result  out  XLEN  final value; W ops are sign-extended from bit 31

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, counter=0, all internal registers=0.
- Accept:
  - Handshake is in_valid & in_ready & op in 19..30.
  - in_valid with any other op is ignored: no state change, no output.
- States IDLE -> CALC -> DONE -> IDLE:
  - IDLE: on accept at edge T, latch operands.
    - Signed ops take absolute values and record the result-negate flag.
    - W ops take the low 32 bits, sign- or zero-extended per op.
    - counter loads N: 64 for 64-bit ops, 32 for W ops.
  - CALC: one iteration per cycle, counter decrements. counter==1 -> DONE, so CALC lasts N cycles (edges T+1..T+N).
  - DONE: out_valid=1 from the cycle after edge T+N; result is stable.
    - out_ready high -> IDLE at the next edge.
    - out_ready low -> hold result and out_valid indefinitely.
- Latency: 65 cycles from accept to out_valid for 64-bit ops, 33 for W ops. Back-to-back issue is possible the cycle after consumption.
- Multiply:
  - 128-bit product accumulator.
  - MUL and MULW return the low bits.
  - MULH, MULHSU and MULHU return bits 127:64, with sign correction (two's-complement negate of the full 128 bits when the flag is set).
  - MULHSU: src1 is signed, src2 is unsigned.
- Divide: restoring; quotient and remainder are formed from magnitudes.
  - Quotient sign = sign1 XOR sign2; remainder sign = sign1.
  - Divide by zero: quotient = all ones (W: 0xFFFFFFFF, then sign-extended), remainder = dividend.
  - Signed overflow (-2^63 / -1, or W -2^31 / -1): quotient = dividend, remainder = 0.
  - Both special cases still take the full N cycles unless the optional feature is enabled.
- flush: has priority over every other input.
  - Next state is IDLE and out_valid drops the next cycle.
  - A simultaneous accept is discarded.
- rst asserted mid-operation: same as reset; no partial result is ever presented.
- result changes only on the transition into DONE.

Optional Feature:
- MDU_EARLY_OUT_EN
- Defined: at accept, the following skip CALC and go straight to DONE, so out_valid appears 2 cycles after accept:
  - divide by zero
  - signed overflow
  - multiply where either operand is zero (result 0)
- Undefined: every op takes the full N iterations, with identical results.

Decomposition:
- Shared package mdu_pkg holds:
  - ALUCtrl code constants 19–30
  - state encoding (IDLE=0, CALC=1, DONE=2)
  - ITER_64=64, ITER_32=32
  - helper predicates is_signed_op, is_word_op, is_div_op and is_rem_op
- One sub-module, mdu_iter, is natural: the combinational single-step shift-add / restore-subtract slice. The FSM, counter and sign fix-up stay in mdu_seq.

Test Plan:
- MUL, src1=7, src2=-3 -> result 0xFFFFFFFFFFFFFFEB, out_valid exactly 65 cycles after accept.
- MULHU 0xFFFFFFFFFFFFFFFF × 2 -> result 1. Same operands with MULH (op 19, hl=1) -> 0xFFFFFFFFFFFFFFFF.
- DIVW 0x80000000 / -1 -> 0xFFFFFFFF80000000, latency 33. REMW of the same operands -> 0.
- DIV 100/0 -> 0xFFFFFFFFFFFFFFFF and REM 100/0 -> 100. Latency is 65 without MDU_EARLY_OUT_EN and 2 with it.
- DIV -7/2 -> -3, REM -7/2 -> -1. Hold out_ready low 10 cycles: result and out_valid are stable and in_ready stays 0.
- Assert flush at CALC cycle 20 -> IDLE next cycle with out_valid never high. An illegal op 5 with in_valid is ignored. rst mid-CALC -> all outputs return to reset values.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants, state encoding and op-class predicates for the RV64M multiply/divide sequencer.
package mdu_pkg;

  localparam logic [4:0] OP_MUL    = 5'd19;
  localparam logic [4:0] OP_MULHSU = 5'd20;
  localparam logic [4:0] OP_MULHU  = 5'd21;
  localparam logic [4:0] OP_MULW   = 5'd22;
  localparam logic [4:0] OP_DIV    = 5'd23;
  localparam logic [4:0] OP_DIVU   = 5'd24;
  localparam logic [4:0] OP_DIVW   = 5'd25;
  localparam logic [4:0] OP_DIVUW  = 5'd26;
  localparam logic [4:0] OP_REM    = 5'd27;
  localparam logic [4:0] OP_REMU   = 5'd28;
  localparam logic [4:0] OP_REMW   = 5'd29;
  localparam logic [4:0] OP_REMUW  = 5'd30;

  localparam int ITER_64 = 64;
  localparam int ITER_32 = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  function automatic logic is_valid_op(input logic [4:0] op);
    return (op >= OP_MUL) && (op <= OP_REMUW);
  endfunction

  // src1 is treated as two's complement
  function automatic logic is_signed_op(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_MULHSU) || (op == OP_DIV) ||
           (op == OP_DIVW) || (op == OP_REM) || (op == OP_REMW);
  endfunction

  // src2 is treated as two's complement (MULHSU keeps src2 unsigned)
  function automatic logic is_signed2_op(input logic [4:0] op);
    return is_signed_op(op) && (op != OP_MULHSU);
  endfunction

  function automatic logic is_word_op(input logic [4:0] op);
    return (op == OP_MULW) || (op == OP_DIVW) || (op == OP_DIVUW) ||
           (op == OP_REMW) || (op == OP_REMUW);
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return (op >= OP_DIV) && (op <= OP_REMUW);
  endfunction

  function automatic logic is_rem_op(input logic [4:0] op);
    return (op >= OP_REM) && (op <= OP_REMUW);
  endfunction

endpackage

// File: rtl/mdu_seq_if.sv
// Issue/result handshake bundle between the execute stage and the multiply/divide sequencer.
interface mdu_seq_if #(parameter int XLEN = 64);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      op;
  logic            hl;
  logic [XLEN-1:0] src1;
  logic [XLEN-1:0] src2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, op, hl, src1, src2, out_ready,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, hl, src1, src2, out_ready,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mdu_iter.sv
// One iteration of the shared datapath: shift-add multiply step or restoring-divide step.
module mdu_iter #(parameter int XLEN = 64) (
  input  logic              div_mode,
  input  logic [2*XLEN-1:0] acc,
  input  logic [2*XLEN-1:0] opa,
  input  logic [XLEN-1:0]   opb,
  output logic [2*XLEN-1:0] acc_nxt,
  output logic [2*XLEN-1:0] opa_nxt,
  output logic [XLEN-1:0]   opb_nxt
);

  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_sub;
  logic            rem_ge;

  // Divide: acc = {remainder, dividend/quotient shift register}, divisor in opa low half.
  // Multiply: acc = product, opa = multiplicand shifted left, opb = multiplier shifted right.
  always_comb begin
    rem_sh  = acc[2*XLEN-1:XLEN-1];
    rem_ge  = rem_sh >= {1'b0, opa[XLEN-1:0]};
    rem_sub = rem_sh[XLEN-1:0] - opa[XLEN-1:0];
    acc_nxt = acc;
    opa_nxt = opa;
    opb_nxt = opb;
    if (div_mode) begin
      if (rem_ge) acc_nxt = {rem_sub, acc[XLEN-2:0], 1'b1};
      else        acc_nxt = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else begin
      acc_nxt = acc + (opb[0] ? opa : '0);
      opa_nxt = {opa[2*XLEN-2:0], 1'b0};
      opb_nxt = {1'b0, opb[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mdu_seq.sv
// RV64M multiply/divide sequencer: one bit per cycle, result held until consumed.
// Optional MDU_EARLY_OUT_EN: divide-by-zero, signed overflow and zero-operand multiply finish after one cycle.
//
// state   | meaning
// IDLE    | ready for a new op
// CALC    | iterating, counter counts down to 1
// DONE    | result valid, waiting for out_ready
module mdu_seq
  import mdu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  mdu_seq_if.slave  bus
);

  localparam logic [XLEN-1:0] D_MIN = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [XLEN-1:0] W_MIN = {{(XLEN-31){1'b1}}, {31{1'b0}}};

  mdu_state_e state, state_nxt;

  logic [6:0]        cnt;
  logic [2*XLEN-1:0] acc, opa;
  logic [XLEN-1:0]   opb;
  logic [4:0]        op_q;
  logic              hl_q, neg_q, use_spec_q;
  logic [XLEN-1:0]   spec_q, result_q;

  logic accept, finish;

  logic              word_in, div_in, rem_in, s1, s2, neg_a, neg_b, div0;
  logic [XLEN-1:0]   a_ext, b_ext, mag_a, mag_b;
  logic [2*XLEN-1:0] acc_ld, opa_ld;
  logic [XLEN-1:0]   opb_ld, spec_ld;
  logic              neg_ld, use_spec_ld;
  logic [6:0]        n_full, n_load;
`ifdef MDU_EARLY_OUT_EN
  logic              ovf, mzero;
  logic [XLEN-1:0]   min_a;
`endif

  logic [2*XLEN-1:0] acc_nxt, opa_nxt, prod;
  logic [XLEN-1:0]   opb_nxt, dv, dv_s, raw, final_val;

  always_comb begin
    state_nxt = state;
    accept    = bus.in_valid && (state == ST_IDLE) && is_valid_op(bus.op) && !flush;
    finish    = (state == ST_CALC) && (cnt == 7'd1) && !flush;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_CALC;
      ST_CALC: if (cnt == 7'd1) state_nxt = ST_DONE;
      ST_DONE: if (bus.out_ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (flush) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Operand preparation at accept: extension, magnitudes, sign flag and special-case result.
  always_comb begin
    word_in = is_word_op(bus.op);
    div_in  = is_div_op(bus.op);
    rem_in  = is_rem_op(bus.op);
    s1      = is_signed_op(bus.op);
    s2      = is_signed2_op(bus.op);
    if (word_in) begin
      a_ext = s1 ? {{(XLEN-32){bus.src1[31]}}, bus.src1[31:0]} : {{(XLEN-32){1'b0}}, bus.src1[31:0]};
      b_ext = s2 ? {{(XLEN-32){bus.src2[31]}}, bus.src2[31:0]} : {{(XLEN-32){1'b0}}, bus.src2[31:0]};
    end else begin
      a_ext = bus.src1;
      b_ext = bus.src2;
    end
    neg_a  = s1 && a_ext[XLEN-1];
    neg_b  = s2 && b_ext[XLEN-1];
    mag_a  = neg_a ? -a_ext : a_ext;
    mag_b  = neg_b ? -b_ext : b_ext;
    neg_ld = rem_in ? neg_a : (neg_a ^ neg_b);
    div0   = div_in && (b_ext == '0);
    n_full = word_in ? 7'(ITER_32) : 7'(ITER_64);
    if (div_in) begin
      // W dividends sit in the upper half so the first shift brings in bit 31
      acc_ld = {{XLEN{1'b0}}, (word_in ? {mag_a[XLEN-33:0], 32'b0} : mag_a)};
      opa_ld = {{XLEN{1'b0}}, mag_b};
      opb_ld = '0;
    end else begin
      acc_ld = '0;
      opa_ld = {{XLEN{1'b0}}, mag_a};
      opb_ld = mag_b;
    end
`ifdef MDU_EARLY_OUT_EN
    min_a       = word_in ? W_MIN : D_MIN;
    ovf         = div_in && s1 && (a_ext == min_a) && (b_ext == '1);
    mzero       = !div_in && ((a_ext == '0) || (b_ext == '0));
    use_spec_ld = div0 || ovf || mzero;
    if (div0)     spec_ld = rem_in ? a_ext : '1;
    else if (ovf) spec_ld = rem_in ? '0 : a_ext;
    else          spec_ld = '0;
    n_load = use_spec_ld ? 7'd1 : n_full;
`else
    use_spec_ld = div0;
    spec_ld     = rem_in ? a_ext : '1;
    n_load      = n_full;
`endif
  end

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .div_mode (is_div_op(op_q)),
    .acc      (acc),
    .opa      (opa),
    .opb      (opb),
    .acc_nxt  (acc_nxt),
    .opa_nxt  (opa_nxt),
    .opb_nxt  (opb_nxt)
  );

  // Sign fix-up and half selection on the value produced by the final iteration.
  always_comb begin
    prod = neg_q ? -acc_nxt : acc_nxt;
    dv   = is_rem_op(op_q) ? acc_nxt[2*XLEN-1:XLEN] : acc_nxt[XLEN-1:0];
    dv_s = neg_q ? -dv : dv;
    if (is_div_op(op_q))
      raw = dv_s;
    else if ((op_q == OP_MULHSU) || (op_q == OP_MULHU) || ((op_q == OP_MUL) && hl_q))
      raw = prod[2*XLEN-1:XLEN];
    else
      raw = prod[XLEN-1:0];
    if (use_spec_q) raw = spec_q;
    final_val = is_word_op(op_q) ? {{(XLEN-32){raw[31]}}, raw[31:0]} : raw;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      acc        <= '0;
      opa        <= '0;
      opb        <= '0;
      op_q       <= '0;
      hl_q       <= 1'b0;
      neg_q      <= 1'b0;
      use_spec_q <= 1'b0;
      spec_q     <= '0;
      result_q   <= '0;
    end else begin
      if (flush) begin
        cnt <= '0;
      end else if (accept) begin
        cnt        <= n_load;
        acc        <= acc_ld;
        opa        <= opa_ld;
        opb        <= opb_ld;
        op_q       <= bus.op;
        hl_q       <= bus.hl;
        neg_q      <= neg_ld;
        use_spec_q <= use_spec_ld;
        spec_q     <= spec_ld;
      end else if (state == ST_CALC) begin
        acc <= acc_nxt;
        opa <= opa_nxt;
        opb <= opb_nxt;
        cnt <= cnt - 7'd1;
      end
      if (finish) result_q <= final_val;
    end
  end

  assign bus.in_ready  = (state == ST_IDLE);
  assign bus.out_valid = (state == ST_DONE);
  assign bus.result    = result_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Scoreboard bench for mdu_seq: directed vectors, latency and result checked by a decoupled monitor.
module tb_mdu_seq;
  import mdu_pkg::*;

`ifdef MDU_EARLY_OUT_EN
  localparam int LAT_S64 = 2;
  localparam int LAT_S32 = 2;
`else
  localparam int LAT_S64 = 65;
  localparam int LAT_S32 = 33;
`endif

  logic clk = 1'b0;
  logic rst, flush;

  mdu_seq_if #(.XLEN(64)) bus ();

  mdu_seq #(.XLEN(64)) dut (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] res;
    int          lat;
    int          acc_cyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  bit   seen_valid = 0;
  bit   unexp = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else n_pass++;
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    else n_pass++;
  endtask

  // Monitor: latency on first out_valid cycle, result on handshake.
  always @(negedge clk) begin
    if (rst) begin
      seen_valid = 0;
    end else if (bus.out_valid) begin
      if (sb.size() == 0) begin
        if (!unexp) check_int("unexpected_out_valid", int'(bus.out_valid), 0);
        unexp = 1;
      end else begin
        if (!seen_valid) begin
          check_int({sb[0].name, "_latency"}, cyc - sb[0].acc_cyc, sb[0].lat);
          seen_valid = 1;
        end
        if (bus.out_ready) begin
          check64(sb[0].name, bus.result, sb[0].res);
          void'(sb.pop_front());
          seen_valid = 0;
        end
      end
    end else begin
      unexp = 0;
    end
  end

  task automatic issue(input logic [4:0] o, input logic h, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int lat, input string nm, input bit push);
    int t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!bus.in_ready && t < 300);
    if (!bus.in_ready) begin
      check_int({nm, "_in_ready_timeout"}, int'(bus.in_ready), 1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.op       = o;
    bus.hl       = h;
    bus.src1     = a;
    bus.src2     = b;
    if (push) sb.push_back('{exp, lat, cyc, nm});
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || bus.out_valid) && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 300) check_int("drain_timeout", sb.size(), 0);
  endtask

  task automatic quiet_window(input string nm);
    int hit = 0;
    repeat (80) begin
      @(posedge clk); #1;
      if (bus.out_valid) hit = 1;
    end
    check_int(nm, hit, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int t;
    rst           = 1'b1;
    flush         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.hl        = 1'b0;
    bus.src1      = '0;
    bus.src2      = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_int("reset_in_ready", int'(bus.in_ready), 1);
    check_int("reset_out_valid", int'(bus.out_valid), 0);
    check64("reset_result", bus.result, 64'h0);

    issue(OP_MUL,    1'b0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 65, "mul", 1);
    issue(OP_MULHU,  1'b0, '1, 64'd2, 64'd1, 65, "mulhu", 1);
    issue(OP_MUL,    1'b1, '1, 64'd2, '1, 65, "mulh", 1);
    issue(OP_MULHSU, 1'b0, '1, 64'd2, '1, 65, "mulhsu", 1);
    issue(OP_MULW,   1'b0, 64'h7FFFFFFF, 64'd2, 64'hFFFFFFFFFFFFFFFE, 33, "mulw", 1);
    issue(OP_MUL,    1'b0, 64'd0, 64'd5, 64'd0, LAT_S64, "mul_zero", 1);
    issue(OP_DIVW,   1'b0, 64'h80000000, '1, 64'hFFFFFFFF80000000, LAT_S32, "divw_ovf", 1);
    issue(OP_REMW,   1'b0, 64'h80000000, '1, 64'd0, LAT_S32, "remw_ovf", 1);
    issue(OP_DIV,    1'b0, 64'd100, 64'd0, '1, LAT_S64, "div_by0", 1);
    issue(OP_REM,    1'b0, 64'd100, 64'd0, 64'd100, LAT_S64, "rem_by0", 1);
    issue(OP_DIVU,   1'b0, 64'd100, 64'd7, 64'd14, 65, "divu", 1);
    issue(OP_REMU,   1'b0, 64'd100, 64'd7, 64'd2, 65, "remu", 1);
    issue(OP_DIVUW,  1'b0, 64'hFFFFFFFF, 64'd1, '1, 33, "divuw", 1);
    issue(OP_REMUW,  1'b0, 64'h80000005, 64'd16, 64'd5, 33, "remuw", 1);
    issue(OP_REM,    1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, '1, 65, "rem_neg", 1);
    drain();

    // Result held while the consumer stalls
    bus.out_ready = 1'b0;
    issue(OP_DIV, 1'b0, 64'hFFFFFFFFFFFFFFF9, 64'd2, 64'hFFFFFFFFFFFFFFFD, 65, "div_neg", 1);
    t = 0;
    while (!bus.out_valid && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check64("hold_result", bus.result, 64'hFFFFFFFFFFFFFFFD);
      check_int("hold_out_valid", int'(bus.out_valid), 1);
      check_int("hold_in_ready", int'(bus.in_ready), 0);
    end
    bus.out_ready = 1'b1;
    drain();

    // Illegal op is ignored
    bus.in_valid = 1'b1;
    bus.op       = 5'd5;
    bus.src1     = 64'd9;
    bus.src2     = 64'd3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check_int("illegal_in_ready", int'(bus.in_ready), 1);
      check_int("illegal_out_valid", int'(bus.out_valid), 0);
    end
    bus.in_valid = 1'b0;

    // Flush coinciding with an accept discards it
    bus.in_valid = 1'b1;
    bus.op       = OP_MUL;
    bus.src1     = 64'd3;
    bus.src2     = 64'd3;
    flush        = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    check_int("flush_accept_in_ready", int'(bus.in_ready), 1);
    quiet_window("flush_accept_no_valid");

    // Flush at CALC cycle 20
    issue(OP_DIV, 1'b0, 64'd1000, 64'd3, 64'd0, 0, "flush_op", 0);
    repeat (19) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check_int("flush_in_ready", int'(bus.in_ready), 1);
    check_int("flush_out_valid", int'(bus.out_valid), 0);
    quiet_window("flush_no_valid");

    issue(OP_DIVU, 1'b0, 64'd1000, 64'd3, 64'd333, 65, "post_flush", 1);
    drain();

    // Reset mid-CALC
    issue(OP_MUL, 1'b0, 64'd5, 64'd5, 64'd0, 0, "rst_op", 0);
    repeat (10) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_int("rst_in_ready", int'(bus.in_ready), 1);
    check_int("rst_out_valid", int'(bus.out_valid), 0);
    check64("rst_result", bus.result, 64'h0);
    quiet_window("rst_no_valid");

    check_int("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
